// File: rtl/sbox_share_ctrl_if.sv
//------------------------------------------------------------------------------
// sbox_share_ctrl_if : request/result bundle between the AES round controller,
// the key scheduler and the shared S-Box scheduler.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sbox_share_ctrl_if;
    logic         i_st_valid;
    logic         o_st_ready;
    logic [127:0] i_st_data;
    logic         o_st_done;
    logic [127:0] o_st_data;
    logic         i_kw_valid;
    logic         o_kw_ready;
    logic [31:0]  i_kw_data;
    logic         o_kw_done;
    logic [31:0]  o_kw_data;
    logic         o_busy;

    modport slave (
        input  i_st_valid, i_st_data, i_kw_valid, i_kw_data,
        output o_st_ready, o_st_done, o_st_data,
        output o_kw_ready, o_kw_done, o_kw_data, o_busy
    );

    modport master (
        output i_st_valid, i_st_data, i_kw_valid, i_kw_data,
        input  o_st_ready, o_st_done, o_st_data,
        input  o_kw_ready, o_kw_done, o_kw_data, o_busy
    );
endinterface

`default_nettype wire

// File: rtl/sbox_share_ctrl.sv
//------------------------------------------------------------------------------
// sbox_share_ctrl : shares four S-Box lanes between round SubBytes (4 beats)
// and key-expansion SubWord (1 beat).  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sbox_share_ctrl #(
    parameter int LANES = 4,
    parameter bit RR_EN = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    sbox_share_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KW_RUN = 2'd1,
        ST_RUN = 2'd2
    } state_t;

    state_t       state_q;
    logic [1:0]   beat_q;
    logic [1:0]   beat_d;
    logic         last_st_q;
    logic [127:0] work_q;
    logic [127:0] st_data_q;
    logic [31:0]  kw_data_q;
    logic         st_done_q;
    logic         kw_done_q;

    logic         w_idle;
    logic         w_kw_ready;
    logic         w_st_ready;
    logic         w_kw_acc;
    logic         w_st_acc;
    logic [31:0]  w_lane_in;
    logic [31:0]  w_lane_out;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (zero maps to zero), then the AES affine map.
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign w_idle     = (state_q == IDLE);
    // On a tie the key side wins unless round-robin says the state side is due.
    assign w_kw_ready = w_idle && (!bus.i_st_valid || !RR_EN || last_st_q);
    assign w_st_ready = w_idle && (!bus.i_kw_valid || (RR_EN && !last_st_q));
    assign w_kw_acc   = bus.i_kw_valid && w_kw_ready;
    assign w_st_acc   = bus.i_st_valid && w_st_ready;
    assign beat_d     = beat_q + 2'd1;

    always_comb begin
        w_lane_in = 32'h0;
        case (state_q)
            KW_RUN:  w_lane_in = work_q[31:0];
            ST_RUN:  w_lane_in = work_q[{beat_q, 5'd0} +: 32];
            default: w_lane_in = 32'h0;
        endcase
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign w_lane_out[8*j +: 8] = sbox_byte(w_lane_in[8*j +: 8]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            beat_q    <= 2'd0;
            last_st_q <= 1'b1;
            work_q    <= 128'h0;
            st_data_q <= 128'h0;
            kw_data_q <= 32'h0;
            st_done_q <= 1'b0;
            kw_done_q <= 1'b0;
        end else begin
            st_done_q <= 1'b0;
            kw_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_kw_acc) begin
                        work_q    <= {96'h0, bus.i_kw_data};
                        last_st_q <= 1'b0;
                        state_q   <= KW_RUN;
                    end else if (w_st_acc) begin
                        work_q    <= bus.i_st_data;
                        last_st_q <= 1'b1;
                        state_q   <= ST_RUN;
                    end
                end
                KW_RUN: begin
                    kw_data_q <= w_lane_out;
                    kw_done_q <= 1'b1;
                    state_q   <= IDLE;
                end
                ST_RUN: begin
                    work_q[{beat_q, 5'd0} +: 32] <= w_lane_out;
                    beat_q <= beat_d;
                    if (beat_q == 2'd3) begin
                        // Last slice comes straight from the lanes; the rest is already in work_q.
                        st_data_q <= {w_lane_out, work_q[95:0]};
                        st_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_st_ready = w_st_ready;
    assign bus.o_kw_ready = w_kw_ready;
    assign bus.o_st_done  = st_done_q;
    assign bus.o_kw_done  = kw_done_q;
    assign bus.o_st_data  = st_data_q;
    assign bus.o_kw_data  = kw_data_q;
    assign bus.o_busy     = !w_idle;

endmodule

`default_nettype wire
